quant_write_coalescer: RTL and testbench

//  Sits directly downstream of the 32-lane quantization stage, in front of the output SRAM port.
//  - Each quantized write fills only one 256-bit quarter of a 1024-bit line (one mask octet).
//  - Merges up to 4 partial writes to the same line address into one full-line SRAM write.
//  - Passes reads through in order.
//  - Flushes partial lines on tag change, read hit, timeout or explicit flush.

---
 rtl/sauria_quant_pkg.sv | 31 +++
 rtl/quant_write_coalescer.sv | 199 +++++++++++++++++++
 tb/tb_quant_write_coalescer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sauria_quant_pkg.sv
// rtl/sauria_quant_pkg.sv - shared types, widths and line-merge helper for the quantized write coalescer
package sauria_quant_pkg;

    localparam int SRAMC_W = 1024;
    localparam int ADRC_W  = 12;
    localparam int SRAMC_N = 32;
    localparam int EW      = SRAMC_W / SRAMC_N;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FILL,
        S_RDHOLD
    } coal_state_e;

    // Mask index k selects element (SRAMC_N-1-k): index 0 is the most significant element.
    function automatic logic [SRAMC_W-1:0] merge_line(
        input logic [SRAMC_W-1:0] buf_in,
        input logic [SRAMC_W-1:0] data,
        input logic [0:SRAMC_N-1] mask
    );
        logic [SRAMC_W-1:0] line;
        line = buf_in;
        for (int k = 0; k < SRAMC_N; k++) begin
            if (mask[k]) begin
                line[(SRAMC_N-1-k)*EW +: EW] = data[(SRAMC_N-1-k)*EW +: EW];
            end
        end
        return line;
    endfunction

endpackage

// File: rtl/quant_write_coalescer.sv
// rtl/quant_write_coalescer.sv - merges quarter-line quantized writes into full SRAM line writes
module quant_write_coalescer
    import sauria_quant_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [SRAMC_W-1:0]   i_sramc_wdata_q,
    input  logic [ADRC_W-1:0]    i_sramc_addr_q,
    input  logic                 i_sramc_wren_q,
    input  logic [0:SRAMC_N-1]   i_sramc_wmask_q,
    input  logic                 i_sramc_rden_q,
    input  logic                 i_flush,
    output logic                 o_ready,
    output logic                 o_empty,
    output logic [SRAMC_W-1:0]   o_sramc_wdata,
    output logic [ADRC_W-1:0]    o_sramc_addr,
    output logic                 o_sramc_wren,
    output logic [0:SRAMC_N-1]   o_sramc_wmask,
    output logic                 o_sramc_rden
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    coal_state_e          r_state, w_nx_state;
    logic [SRAMC_W-1:0]   r_buf, w_nx_buf;
    logic [ADRC_W-1:0]    r_tag, w_nx_tag;
    logic [0:SRAMC_N-1]   r_acc, w_nx_acc;
    logic                 r_force, w_nx_force;
    logic                 r_skid_v, w_nx_skid_v;
    logic [ADRC_W-1:0]    r_skid_a, w_nx_skid_a;
    logic [7:0]           r_timer, w_nx_timer;
    logic                 r_ready, w_nx_ready;
    logic                 r_empty, w_nx_empty;
    logic [SRAMC_W-1:0]   r_wdata, w_nx_wdata;
    logic [ADRC_W-1:0]    r_addr, w_nx_addr;
    logic                 r_wren, w_nx_wren;
    logic [0:SRAMC_N-1]   r_wmask, w_nx_wmask;
    logic                 r_rden, w_nx_rden;

    logic                 w_wr, w_rd, w_hit;
    logic [SRAMC_W-1:0]   w_load, w_merge;
    logic [0:SRAMC_N-1]   w_acc_m;

    // Requests are only honoured while ready; wren takes priority over rden.
    assign w_wr    = r_ready && i_sramc_wren_q && (|i_sramc_wmask_q);
    assign w_rd    = r_ready && i_sramc_rden_q && !i_sramc_wren_q;
    assign w_hit   = (i_sramc_addr_q == r_tag);
    assign w_load  = merge_line('0, i_sramc_wdata_q, i_sramc_wmask_q);
    assign w_merge = merge_line(r_buf, i_sramc_wdata_q, i_sramc_wmask_q);
    assign w_acc_m = r_acc | i_sramc_wmask_q;

    always_comb begin
        w_nx_state  = r_state;
        w_nx_buf    = r_buf;
        w_nx_tag    = r_tag;
        w_nx_acc    = r_acc;
        w_nx_force  = r_force;
        w_nx_skid_v = r_skid_v;
        w_nx_skid_a = r_skid_a;
        w_nx_timer  = r_timer;
        w_nx_ready  = 1'b1;
        w_nx_wdata  = r_wdata;
        w_nx_addr   = r_addr;
        w_nx_wmask  = r_wmask;
        w_nx_wren   = 1'b0;
        w_nx_rden   = 1'b0;

        case (r_state)
            S_EMPTY: begin
                if (w_wr) begin
                    if ((&i_sramc_wmask_q) || i_flush) begin
                        w_nx_wren  = 1'b1;
                        w_nx_addr  = i_sramc_addr_q;
                        w_nx_wdata = w_load;
                        w_nx_wmask = i_sramc_wmask_q;
                    end else begin
                        w_nx_buf   = w_load;
                        w_nx_tag   = i_sramc_addr_q;
                        w_nx_acc   = i_sramc_wmask_q;
                        w_nx_timer = '0;
                        w_nx_force = 1'b0;
                        w_nx_state = S_FILL;
                    end
                end else if (w_rd) begin
                    w_nx_rden = 1'b1;
                    w_nx_addr = i_sramc_addr_q;
                end
            end
            S_FILL: begin
                if (w_wr && w_hit) begin
                    w_nx_timer = '0;
                    if ((&w_acc_m) || i_flush) begin
                        w_nx_wren  = 1'b1;
                        w_nx_addr  = r_tag;
                        w_nx_wdata = w_merge;
                        w_nx_wmask = w_acc_m;
                        w_nx_force = 1'b0;
                        w_nx_state = S_EMPTY;
                    end else begin
                        w_nx_buf = w_merge;
                        w_nx_acc = w_acc_m;
                    end
                end else if (w_wr) begin
                    // Only one SRAM op per cycle: a full or flushed new line drains on the next free cycle.
                    w_nx_wren  = 1'b1;
                    w_nx_addr  = r_tag;
                    w_nx_wdata = r_buf;
                    w_nx_wmask = r_acc;
                    w_nx_buf   = w_load;
                    w_nx_tag   = i_sramc_addr_q;
                    w_nx_acc   = i_sramc_wmask_q;
                    w_nx_timer = '0;
                    w_nx_force = i_flush || (&i_sramc_wmask_q);
                end else if (w_rd && (w_hit || i_flush)) begin
                    w_nx_wren   = 1'b1;
                    w_nx_addr   = r_tag;
                    w_nx_wdata  = r_buf;
                    w_nx_wmask  = r_acc;
                    w_nx_skid_v = 1'b1;
                    w_nx_skid_a = i_sramc_addr_q;
                    w_nx_ready  = 1'b0;
                    w_nx_force  = 1'b0;
                    w_nx_state  = S_RDHOLD;
                end else if (w_rd) begin
                    w_nx_rden  = 1'b1;
                    w_nx_addr  = i_sramc_addr_q;
                    w_nx_timer = '0;
                end else if (i_flush || r_force || (r_timer >= TMO_LAST)) begin
                    w_nx_wren  = 1'b1;
                    w_nx_addr  = r_tag;
                    w_nx_wdata = r_buf;
                    w_nx_wmask = r_acc;
                    w_nx_force = 1'b0;
                    w_nx_state = S_EMPTY;
                end else if (r_timer != 8'hFF) begin
                    w_nx_timer = r_timer + 8'd1;
                end
            end
            S_RDHOLD: begin
                w_nx_rden   = 1'b1;
                w_nx_addr   = r_skid_a;
                w_nx_skid_v = 1'b0;
                w_nx_state  = S_EMPTY;
            end
            default: begin
                w_nx_state = S_EMPTY;
            end
        endcase

        w_nx_empty = (w_nx_state == S_EMPTY) && !w_nx_skid_v;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state  <= S_EMPTY;
            r_buf    <= '0;
            r_tag    <= '0;
            r_acc    <= '0;
            r_force  <= 1'b0;
            r_skid_v <= 1'b0;
            r_skid_a <= '0;
            r_timer  <= '0;
            r_ready  <= 1'b1;
            r_empty  <= 1'b1;
            r_wdata  <= '0;
            r_addr   <= '0;
            r_wren   <= 1'b0;
            r_wmask  <= '0;
            r_rden   <= 1'b0;
        end else begin
            r_state  <= w_nx_state;
            r_buf    <= w_nx_buf;
            r_tag    <= w_nx_tag;
            r_acc    <= w_nx_acc;
            r_force  <= w_nx_force;
            r_skid_v <= w_nx_skid_v;
            r_skid_a <= w_nx_skid_a;
            r_timer  <= w_nx_timer;
            r_ready  <= w_nx_ready;
            r_empty  <= w_nx_empty;
            r_wdata  <= w_nx_wdata;
            r_addr   <= w_nx_addr;
            r_wren   <= w_nx_wren;
            r_wmask  <= w_nx_wmask;
            r_rden   <= w_nx_rden;
        end
    end

    assign o_ready       = r_ready;
    assign o_empty       = r_empty;
    assign o_sramc_wdata = r_wdata;
    assign o_sramc_addr  = r_addr;
    assign o_sramc_wren  = r_wren;
    assign o_sramc_wmask = r_wmask;
    assign o_sramc_rden  = r_rden;

endmodule

// File: tb/tb_quant_write_coalescer.sv
// tb/tb_quant_write_coalescer.sv - directed self-checking bench for quant_write_coalescer
module tb_quant_write_coalescer;

    logic           i_clk = 1'b0;
    logic           i_rstn;
    logic [1023:0]  i_sramc_wdata_q;
    logic [11:0]    i_sramc_addr_q;
    logic           i_sramc_wren_q;
    logic [0:31]    i_sramc_wmask_q;
    logic           i_sramc_rden_q;
    logic           i_flush;
    logic           o_ready;
    logic           o_empty;
    logic [1023:0]  o_sramc_wdata;
    logic [11:0]    o_sramc_addr;
    logic           o_sramc_wren;
    logic [0:31]    o_sramc_wmask;
    logic           o_sramc_rden;

    int n_checks = 0;
    int n_errors = 0;

    quant_write_coalescer #(.TIMEOUT(16)) dut (
        .i_clk           (i_clk),
        .i_rstn          (i_rstn),
        .i_sramc_wdata_q (i_sramc_wdata_q),
        .i_sramc_addr_q  (i_sramc_addr_q),
        .i_sramc_wren_q  (i_sramc_wren_q),
        .i_sramc_wmask_q (i_sramc_wmask_q),
        .i_sramc_rden_q  (i_sramc_rden_q),
        .i_flush         (i_flush),
        .o_ready         (o_ready),
        .o_empty         (o_empty),
        .o_sramc_wdata   (o_sramc_wdata),
        .o_sramc_addr    (o_sramc_addr),
        .o_sramc_wren    (o_sramc_wren),
        .o_sramc_wmask   (o_sramc_wmask),
        .o_sramc_rden    (o_sramc_rden)
    );

    always #5 i_clk = ~i_clk;

    // Element e (bits e*32+:32) of a word carries seed and its own index.
    function automatic logic [1023:0] word(input logic [7:0] s);
        logic [1023:0] w;
        for (int e = 0; e < 32; e++) w[e*32 +: 32] = {s, 8'(e), 16'hC0DE};
        return w;
    endfunction

    function automatic logic [31:0] qmask(input int q);
        return 32'hFF << (8 * q);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_idle();
        i_sramc_wren_q  = 1'b0;
        i_sramc_rden_q  = 1'b0;
        i_flush         = 1'b0;
        i_sramc_wmask_q = '0;
        i_sramc_wdata_q = '0;
        i_sramc_addr_q  = '0;
    endtask

    task automatic set_wr(input logic [11:0] a, input logic [7:0] s, input logic [31:0] m);
        set_idle();
        i_sramc_wren_q  = 1'b1;
        i_sramc_addr_q  = a;
        i_sramc_wdata_q = word(s);
        i_sramc_wmask_q = m;
    endtask

    task automatic set_rd(input logic [11:0] a);
        set_idle();
        i_sramc_rden_q = 1'b1;
        i_sramc_addr_q = a;
    endtask

    logic [1023:0] exp_line;
    int            n_wait;

    initial begin
        set_idle();
        i_rstn = 1'b0;
        step();
        step();
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_empty", 64'(o_empty), 64'd1);
        chk("rst_wren",  64'(o_sramc_wren), 64'd0);
        chk("rst_rden",  64'(o_sramc_rden), 64'd0);
        chk("rst_addr",  64'(o_sramc_addr), 64'd0);
        chk("rst_wmask", 64'(o_sramc_wmask), 64'd0);
        chk("rst_wdata", 64'(o_sramc_wdata == '0), 64'd1);
        i_rstn = 1'b1;
        step();

        // 1: four quarters to line 5 coalesce into one full write
        for (int q = 0; q < 4; q++) begin
            set_wr(12'd5, 8'h10 + 8'(q), qmask(q));
            exp_line[q*256 +: 256] = word(8'h10 + 8'(q))[q*256 +: 256];
            step();
            if (q < 3) chk($sformatf("t1_nowr_q%0d", q), 64'(o_sramc_wren), 64'd0);
            if (q == 0) chk("t1_empty0", 64'(o_empty), 64'd0);
        end
        chk("t1_wren",  64'(o_sramc_wren), 64'd1);
        chk("t1_addr",  64'(o_sramc_addr), 64'd5);
        chk("t1_mask",  64'(o_sramc_wmask), 64'hFFFF_FFFF);
        chk("t1_data",  64'(o_sramc_wdata === exp_line), 64'd1);
        set_idle();
        step();
        chk("t1_pulse", 64'(o_sramc_wren), 64'd0);
        chk("t1_empty", 64'(o_empty), 64'd1);

        // 2: tag change evicts the partial line 7
        set_wr(12'd7, 8'h20, qmask(0)); step();
        set_wr(12'd7, 8'h21, qmask(1)); step();
        chk("t2_nowr", 64'(o_sramc_wren), 64'd0);
        set_wr(12'd8, 8'h22, qmask(2)); step();
        exp_line = '0;
        exp_line[255:0]   = word(8'h20)[255:0];
        exp_line[511:256] = word(8'h21)[511:256];
        chk("t2_wren",  64'(o_sramc_wren), 64'd1);
        chk("t2_addr",  64'(o_sramc_addr), 64'd7);
        chk("t2_mask",  64'(o_sramc_wmask), 64'h0000_FFFF);
        chk("t2_data",  64'(o_sramc_wdata === exp_line), 64'd1);
        chk("t2_empty", 64'(o_empty), 64'd0);
        set_idle(); i_flush = 1'b1; step();
        chk("t2_fl_wren", 64'(o_sramc_wren), 64'd1);
        chk("t2_fl_addr", 64'(o_sramc_addr), 64'd8);
        chk("t2_fl_mask", 64'(o_sramc_wmask), 64'h00FF_0000);
        set_idle(); step();
        chk("t2_fl_empty", 64'(o_empty), 64'd1);

        // 3: read hit parks the read behind the line write
        set_wr(12'd3, 8'h30, qmask(1)); step();
        set_rd(12'd3); step();
        chk("t3_hit_wren",  64'(o_sramc_wren), 64'd1);
        chk("t3_hit_addr",  64'(o_sramc_addr), 64'd3);
        chk("t3_hit_mask",  64'(o_sramc_wmask), 64'h0000_FF00);
        chk("t3_hit_rden",  64'(o_sramc_rden), 64'd0);
        chk("t3_hit_ready", 64'(o_ready), 64'd0);
        set_idle(); step();
        chk("t3_rd_rden",  64'(o_sramc_rden), 64'd1);
        chk("t3_rd_wren",  64'(o_sramc_wren), 64'd0);
        chk("t3_rd_addr",  64'(o_sramc_addr), 64'd3);
        chk("t3_rd_ready", 64'(o_ready), 64'd1);
        chk("t3_rd_empty", 64'(o_empty), 64'd1);
        set_wr(12'd3, 8'h31, qmask(0)); step();
        set_rd(12'd9); step();
        chk("t3_miss_rden",  64'(o_sramc_rden), 64'd1);
        chk("t3_miss_wren",  64'(o_sramc_wren), 64'd0);
        chk("t3_miss_addr",  64'(o_sramc_addr), 64'd9);
        chk("t3_miss_empty", 64'(o_empty), 64'd0);
        set_idle(); i_flush = 1'b1; step();
        chk("t3_fl_wren", 64'(o_sramc_wren), 64'd1);
        chk("t3_fl_addr", 64'(o_sramc_addr), 64'd3);
        chk("t3_fl_mask", 64'(o_sramc_wmask), 64'h0000_00FF);
        set_idle(); step();

        // 4: idle timeout drains the pending line after 16 cycles
        set_wr(12'd2, 8'h40, qmask(0)); step();
        set_idle();
        n_wait = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (o_sramc_wren) begin
                n_wait = n;
                break;
            end
        end
        chk("t4_cycles", 64'(n_wait), 64'd16);
        chk("t4_addr",   64'(o_sramc_addr), 64'd2);
        chk("t4_mask",   64'(o_sramc_wmask), 64'h0000_00FF);
        set_idle(); i_flush = 1'b1; step();
        chk("t4_eflush_wren", 64'(o_sramc_wren), 64'd0);
        chk("t4_eflush_rden", 64'(o_sramc_rden), 64'd0);
        chk("t4_eflush_empty", 64'(o_empty), 64'd1);

        // 5: full-mask write-through and zero-mask no-op
        set_wr(12'd11, 8'h50, 32'hFFFF_FFFF); step();
        chk("t5_wt_wren",  64'(o_sramc_wren), 64'd1);
        chk("t5_wt_addr",  64'(o_sramc_addr), 64'd11);
        chk("t5_wt_data",  64'(o_sramc_wdata === word(8'h50)), 64'd1);
        chk("t5_wt_empty", 64'(o_empty), 64'd1);
        set_wr(12'd12, 8'h51, 32'h0); step();
        chk("t5_z_wren",  64'(o_sramc_wren), 64'd0);
        chk("t5_z_empty", 64'(o_empty), 64'd1);

        // 6: async reset discards a 3/4-filled line
        for (int q = 0; q < 3; q++) begin
            set_wr(12'd4, 8'h60 + 8'(q), qmask(q));
            step();
        end
        set_idle();
        #2 i_rstn = 1'b0;
        #1;
        chk("t6_rst_ready", 64'(o_ready), 64'd1);
        chk("t6_rst_empty", 64'(o_empty), 64'd1);
        chk("t6_rst_wren",  64'(o_sramc_wren), 64'd0);
        chk("t6_rst_addr",  64'(o_sramc_addr), 64'd0);
        chk("t6_rst_mask",  64'(o_sramc_wmask), 64'd0);
        step();
        i_rstn = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step();
            if (o_sramc_wren) chk("t6_stray_wren", 64'(o_sramc_wren), 64'd0);
        end
        for (int q = 0; q < 4; q++) begin
            set_wr(12'd6, 8'h70 + 8'(q), qmask(3 - q));
            exp_line[(3-q)*256 +: 256] = word(8'h70 + 8'(q))[(3-q)*256 +: 256];
            step();
        end
        chk("t6_wren", 64'(o_sramc_wren), 64'd1);
        chk("t6_addr", 64'(o_sramc_addr), 64'd6);
        chk("t6_mask", 64'(o_sramc_wmask), 64'hFFFF_FFFF);
        chk("t6_data", 64'(o_sramc_wdata === exp_line), 64'd1);
        set_idle(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
